// File: rtl/bcd_decoder_serial.sv
// Serial BCD-to-binary converter: one digit per cycle, most significant first,
// with a valid/ready operand port and a valid/ready result port.
module bcd_decoder_serial #(
    parameter int N = 3,
    localparam int W = 3 * N + (N + 2) / 3
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           i_valid,
    output logic           o_ready,
    input  logic [4*N-1:0] i_bcd,
    output logic           o_valid,
    input  logic           i_ready,
    output logic [W-1:0]   o_bin,
    output logic           o_err,
    output logic           o_busy,
    output logic [1:0]     o_dbg_state
);

    // Handshake: a transfer happens on a rising edge where valid and ready are
    // both high; o_ready is high only in IDLE, o_valid only in DONE, and both
    // are pure state decodes so neither depends combinationally on any input.

    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam int WX = W + 4;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CONVERT = 2'd1,
        DONE    = 2'd2
    } state_t;

    state_t          r_state;
    logic [4*N-1:0]  r_digits;
    logic [W-1:0]    r_acc;
    logic            r_err;
    logic [CW-1:0]   r_cnt;
    logic            r_ready;
    logic            r_valid;
    logic            r_busy;

    logic [3:0]      w_msd;
    logic [WX-1:0]   w_acc_ext;
    logic [WX-1:0]   w_mac;

    assign w_msd     = r_digits[4*N-1 -: 4];
    assign w_acc_ext = {4'b0000, r_acc};
    // acc*10 + msd with headroom so invalid digits wrap only on the store
    assign w_mac     = (w_acc_ext << 3) + (w_acc_ext << 1) + {{(WX-4){1'b0}}, w_msd};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_digits <= '0;
            r_acc    <= '0;
            r_err    <= 1'b0;
            r_cnt    <= '0;
            r_ready  <= 1'b1;
            r_valid  <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (i_valid) begin
                        r_digits <= i_bcd;
                        r_acc    <= '0;
                        r_err    <= 1'b0;
                        r_cnt    <= '0;
                        r_state  <= CONVERT;
                        r_ready  <= 1'b0;
                        r_busy   <= 1'b1;
                    end
                end
                CONVERT: begin
                    r_acc    <= w_mac[W-1:0];
                    r_err    <= r_err | (w_msd > 4'd9);
                    r_digits <= r_digits << 4;
                    r_cnt    <= r_cnt + CW'(1);
                    if (r_cnt == LAST) begin
                        r_state <= DONE;
                        r_busy  <= 1'b0;
                        r_valid <= 1'b1;
                    end
                end
                DONE: begin
                    if (i_ready) begin
                        r_state <= IDLE;
                        r_valid <= 1'b0;
                        r_ready <= 1'b1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_ready <= 1'b1;
                    r_valid <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign o_ready     = r_ready;
    assign o_valid     = r_valid;
    assign o_busy      = r_busy;
    assign o_bin       = r_acc;
    assign o_err       = r_err;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_bcd_decoder_serial.sv
// Bench for bcd_decoder_serial (N=3): table of known conversions, hand-written
// reset/backpressure sequences, and random back-to-back operands.
module tb_bcd_decoder_serial;

    localparam int N = 3;
    localparam int W = 10;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           i_valid = 1'b0;
    logic [4*N-1:0] i_bcd = '0;
    logic           i_ready = 1'b1;
    logic           o_ready;
    logic           o_valid;
    logic [W-1:0]   o_bin;
    logic           o_err;
    logic           o_busy;
    logic [1:0]     o_dbg_state;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    logic [W:0] exp_q[$];

    typedef struct {
        logic [11:0] bcd;
        logic [9:0]  bin;
        logic        err;
    } vec_t;

    bcd_decoder_serial #(.N(N)) dut (
        .clk(clk), .rst(rst), .i_valid(i_valid), .o_ready(o_ready),
        .i_bcd(i_bcd), .o_valid(o_valid), .i_ready(i_ready),
        .o_bin(o_bin), .o_err(o_err), .o_busy(o_busy),
        .o_dbg_state(o_dbg_state)
    );

    // clock / cycle counter
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at cycle %0d",
                     name, act, act, exp, exp, cyc);
        end
    endtask

    // Reference: digit-serial multiply-accumulate, wrapped to W bits
    function automatic logic [W:0] model(input logic [11:0] bcd);
        int acc = 0;
        logic err = 1'b0;
        for (int d = N - 1; d >= 0; d--) begin
            int dig = int'(bcd[4*d +: 4]);
            acc = (acc * 10 + dig) % (1 << W);
            if (dig > 9) err = 1'b1;
        end
        return {err, acc[W-1:0]};
    endfunction

    // Accept one operand, track it through CONVERT and DONE, release it.
    // Returns the cycle number of acceptance.
    task automatic run_op(input logic [11:0] bcd, input logic [W:0] exp,
                          input int hold, input bit rnd, output int acc_cyc);
        int guard = 0;
        logic [W-1:0] bin_seen;
        logic         err_seen;
        logic [W:0]   e;
        while (!o_ready && guard < 20) begin
            tick();
            guard++;
        end
        check("ready_before_accept", o_ready, 1);
        i_valid = 1'b1;
        i_bcd   = bcd;
        i_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        exp_q.push_back(exp);
        acc_cyc = cyc;
        tick();
        for (int c = 1; c <= N; c++) begin
            i_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
            i_bcd   = rnd ? 12'($urandom_range(0, 4095)) : bcd;
            i_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            check("busy_in_convert", {o_busy, o_valid, o_ready}, 3'b100);
            tick();
        end
        check("valid_latency", {o_valid, o_busy, o_ready}, 3'b100);
        e = exp_q.pop_front();
        check("bin", o_bin, e[W-1:0]);
        check("err", o_err, e[W]);
        bin_seen = o_bin;
        err_seen = o_err;
        for (int h = 0; h < hold; h++) begin
            i_ready = 1'b0;
            i_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
            i_bcd   = rnd ? 12'($urandom_range(0, 4095)) : i_bcd;
            tick();
            check("hold_state", {o_valid, o_ready, o_busy}, 3'b100);
            check("hold_bin", o_bin, bin_seen);
            check("hold_err", o_err, err_seen);
        end
        i_ready = 1'b1;
        i_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
        tick();
        check("back_to_idle", {o_ready, o_valid, o_busy}, 3'b100);
        i_valid = 1'b0;
    endtask

    initial begin
        vec_t vecs[8];
        int   a0, a1;
        logic [11:0] r;

        vecs[0] = '{12'h395, 10'd395, 1'b0};
        vecs[1] = '{12'h999, 10'd999, 1'b0};
        vecs[2] = '{12'h000, 10'd0,   1'b0};
        vecs[3] = '{12'h3A5, 10'd405, 1'b1};
        vecs[4] = '{12'hFFF, 10'd641, 1'b1};
        vecs[5] = '{12'h001, 10'd1,   1'b0};
        vecs[6] = '{12'h900, 10'd900, 1'b0};
        vecs[7] = '{12'h0A0, 10'd100, 1'b1};

        // reset state
        tick();
        tick();
        rst = 1'b0;
        check("reset_outputs", {o_ready, o_valid, o_busy, o_err}, 4'b1000);
        check("reset_bin", o_bin, 0);
        check("reset_state", o_dbg_state, 0);

        // known-answer table, some with backpressure
        for (int i = 0; i < 8; i++) begin
            run_op(vecs[i].bcd, {vecs[i].err, vecs[i].bin}, (i == 1) ? 5 : (i % 3), 1'b0, a0);
        end

        // reset in the second CONVERT cycle
        i_valid = 1'b1;
        i_bcd   = 12'h777;
        tick();
        i_valid = 1'b0;
        tick();
        check("mid_convert_busy", o_busy, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_convert_outputs", {o_ready, o_valid, o_busy, o_err}, 4'b1000);
        check("rst_convert_bin", o_bin, 0);
        for (int k = 0; k < 5; k++) begin
            tick();
            check("no_valid_after_rst", {o_valid, o_busy}, 2'b00);
        end
        run_op(12'h042, 11'd42, 0, 1'b0, a0);

        // i_valid together with rst is not accepted
        rst = 1'b1;
        i_valid = 1'b1;
        i_bcd = 12'h123;
        tick();
        rst = 1'b0;
        i_valid = 1'b0;
        tick();
        check("rst_beats_valid", {o_ready, o_busy, o_valid}, 3'b100);

        // reset while holding a result in DONE
        i_valid = 1'b1;
        i_bcd = 12'h555;
        tick();
        i_valid = 1'b0;
        i_ready = 1'b0;
        for (int k = 0; k < N; k++) tick();
        check("done_reached", o_valid, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        i_ready = 1'b1;
        check("rst_done_outputs", {o_ready, o_valid, o_busy, o_err}, 4'b1000);
        check("rst_done_bin", o_bin, 0);

        // random operands, random input noise, back-to-back throughput
        run_op(12'h111, model(12'h111), 0, 1'b1, a0);
        for (int i = 0; i < 40; i++) begin
            r = ($urandom_range(0, 3) == 0) ? 12'($urandom_range(0, 4095))
                : {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
            run_op(r, model(r), 0, 1'b1, a1);
            check("throughput", a1 - a0, N + 2);
            a0 = a1;
        end
        for (int i = 0; i < 10; i++) begin
            r = 12'($urandom_range(0, 4095));
            run_op(r, model(r), $urandom_range(0, 4), 1'b1, a0);
        end

        check("queue_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
